// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory serving one write burst and one read burst concurrently over a shared word array.
// Read data is looked up combinationally and registered; a beat advances only on RVALID&&RREADY.
module axi4_mem_responder #(
  parameter int                      AXI_WIDTH_ID  = 4,
  parameter int                      AXI_WIDTH_AD  = 32,
  parameter int                      AXI_WIDTH_DA  = 32,
  parameter int                      AXI_WIDTH_DS  = AXI_WIDTH_DA/8,
  parameter logic [AXI_WIDTH_AD-1:0] ADDR_BASE     = 32'h0000_0000,
  parameter int                      SIZE_IN_BYTES = 4096
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [AXI_WIDTH_ID-1:0] AWID,
  input  logic [AXI_WIDTH_AD-1:0] AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [AXI_WIDTH_DA-1:0] WDATA,
  input  logic [AXI_WIDTH_DS-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [AXI_WIDTH_ID-1:0] BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [AXI_WIDTH_ID-1:0] ARID,
  input  logic [AXI_WIDTH_AD-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [AXI_WIDTH_ID-1:0] RID,
  output logic [AXI_WIDTH_DA-1:0] RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int                      LSB       = $clog2(AXI_WIDTH_DS);
  localparam int                      MSB       = $clog2(SIZE_IN_BYTES);
  localparam int                      IDXW      = MSB - LSB;
  localparam int                      DEPTH     = SIZE_IN_BYTES / AXI_WIDTH_DS;
  localparam logic [2:0]              SIZE_MAX  = 3'(LSB);
  localparam logic [AXI_WIDTH_AD-1:0] MEM_BYTES = AXI_WIDTH_AD'(SIZE_IN_BYTES);
  localparam logic [1:0]              BURST_FIXED = 2'b00;
  localparam logic [1:0]              BURST_WRAP  = 2'b10;
  localparam logic [1:0]              RESP_OKAY   = 2'b00;
  localparam logic [1:0]              RESP_SLVERR = 2'b10;

  logic [AXI_WIDTH_DA-1:0] r_mem [0:DEPTH-1];

  // Offset compare also rejects addresses below ADDR_BASE, since the subtraction wraps high.
  function automatic logic f_in_range(input logic [AXI_WIDTH_AD-1:0] a);
    return (a - ADDR_BASE) < MEM_BYTES;
  endfunction

  function automatic logic [IDXW-1:0] f_idx(input logic [AXI_WIDTH_AD-1:0] a);
    return IDXW'((a - ADDR_BASE) >> LSB);
  endfunction

  function automatic logic [AXI_WIDTH_AD-1:0] f_next(input logic [AXI_WIDTH_AD-1:0] a,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + (AXI_WIDTH_AD'(1) << size);
  endfunction

  function automatic logic f_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (size > SIZE_MAX);
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t r_wstate, w_wstate_nxt;

  logic [AXI_WIDTH_ID-1:0] r_wid;
  logic [AXI_WIDTH_AD-1:0] r_waddr;
  logic [7:0]              r_wlen, r_wcnt;
  logic [2:0]              r_wsize;
  logic [1:0]              r_wburst;
  logic                    r_wbad, r_werr;
  logic                    w_aw_hs, w_w_hs, w_wlast_beat, w_win, w_wen;
  logic [IDXW-1:0]         w_widx;

  assign w_aw_hs      = AWVALID && AWREADY;
  assign w_w_hs       = WVALID && WREADY;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_win        = f_in_range(r_waddr);
  assign w_wen        = w_w_hs && !r_wbad && w_win;
  assign w_widx       = f_idx(r_waddr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_wlast_beat) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid    <= AWID;
      r_waddr  <= AWADDR;
      r_wlen   <= AWLEN;
      r_wcnt   <= '0;
      r_wsize  <= AWSIZE;
      r_wburst <= AWBURST;
      r_wbad   <= f_bad(AWBURST, AWSIZE);
      r_werr   <= f_bad(AWBURST, AWSIZE);
    end else if (w_w_hs) begin
      r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
      r_wcnt  <= r_wcnt + 8'd1;
      // WLAST disagreeing with the beat count is flagged; the count still ends the burst.
      if (r_wbad || !w_win || (WLAST != w_wlast_beat)) r_werr <= 1'b1;
    end
  end

  assign BID   = r_wid;
  assign BRESP = r_werr ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge ACLK) begin
    if (w_wen) begin
      for (int b = 0; b < AXI_WIDTH_DS; b++) begin
        if (WSTRB[b]) r_mem[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t r_rstate, w_rstate_nxt;

  logic [AXI_WIDTH_ID-1:0] r_rid;
  logic [AXI_WIDTH_AD-1:0] r_raddr;
  logic [7:0]              r_rlen, r_rcnt;
  logic [2:0]              r_rsize;
  logic [1:0]              r_rburst;
  logic                    r_rbad, r_rlast;
  logic [1:0]              r_rresp;
  logic [AXI_WIDTH_DA-1:0] r_rdata;
  logic                    w_ar_hs, w_r_hs, w_rlast_beat;
  logic [AXI_WIDTH_AD-1:0] w_rlook_addr;
  logic                    w_rlook_bad, w_rlook_in;
  logic [AXI_WIDTH_DA-1:0] w_rlook_dat;

  assign w_ar_hs      = ARVALID && ARREADY;
  assign w_r_hs       = RVALID && RREADY;
  assign w_rlast_beat = (r_rcnt == r_rlen);

  // In idle the lookup serves the incoming AR so the first beat is ready one cycle later.
  assign w_rlook_addr = (r_rstate == R_IDLE) ? ARADDR : f_next(r_raddr, r_rsize, r_rburst);
  assign w_rlook_bad  = (r_rstate == R_IDLE) ? f_bad(ARBURST, ARSIZE) : r_rbad;
  assign w_rlook_in   = f_in_range(w_rlook_addr);
  assign w_rlook_dat  = w_rlook_in ? r_mem[f_idx(w_rlook_addr)] : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && w_rlast_beat) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbad   <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rid    <= ARID;
      r_raddr  <= ARADDR;
      r_rlen   <= ARLEN;
      r_rcnt   <= '0;
      r_rsize  <= ARSIZE;
      r_rburst <= ARBURST;
      r_rbad   <= w_rlook_bad;
      r_rlast  <= (ARLEN == 8'd0);
      r_rresp  <= (w_rlook_bad || !w_rlook_in) ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= w_rlook_dat;
    end else if (w_r_hs && !w_rlast_beat) begin
      r_raddr <= w_rlook_addr;
      r_rcnt  <= r_rcnt + 8'd1;
      r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
      r_rresp <= (w_rlook_bad || !w_rlook_in) ? RESP_SLVERR : RESP_OKAY;
      r_rdata <= w_rlook_dat;
    end
  end

  assign RID   = r_rid;
  assign RDATA = r_rdata;
  assign RRESP = r_rresp;
  assign RLAST = r_rlast;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Bench for axi4_mem_responder: a word model plus a read-beat scoreboard filled at AR issue and drained on R handshakes.
module tb_axi4_mem_responder;
  localparam int          MEMB = 4096;
  localparam logic [31:0] BASE = 32'h0;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi4_mem_responder dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic [1:0]  resp;
    logic        chk;
  } rexp_t;

  rexp_t       sb[$];
  logic [31:0] wbuf  [0:255];
  logic [3:0]  sbuf  [0:255];
  logic [31:0] model [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int t;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL aw_timeout AWREADY=%b required 1", AWREADY); end
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic wlast_early);
    logic [31:0] a;
    int t;
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      WDATA = wbuf[k]; WSTRB = sbuf[k]; WVALID = 1'b1;
      WLAST = wlast_early ? (k == 0) : (k == int'(len));
      t = 0;
      while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
      checks++;
      if (WREADY !== 1'b1) begin errors++; $display("FAIL w_timeout beat %0d WREADY=%b required 1", k, WREADY); end
      if (burst != 2'b10 && (a - BASE) < MEMB)
        for (int b = 0; b < 4; b++)
          if (sbuf[k][b]) model[a[11:2]][8*b +: 8] = wbuf[k][8*b +: 8];
      if (burst == 2'b01) a = a + 32'd4;
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] exp_resp, input int hold);
    int t;
    BREADY = (hold == 0);
    t = 0;
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    checks++;
    if (BVALID !== 1'b1) begin errors++; $display("FAIL b_timeout BVALID=%b required 1", BVALID); end
    checks++;
    if (BID !== id || BRESP !== exp_resp) begin
      errors++; $display("FAIL bresp BID=%h BRESP=%b required BID=%h BRESP=%b", BID, BRESP, id, exp_resp);
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (BVALID !== 1'b1) begin errors++; $display("FAIL b_hold cycle %0d BVALID=%b required 1", i, BVALID); end
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (BVALID !== 1'b0) begin errors++; $display("FAIL b_drop BVALID=%b required 0", BVALID); end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic wlast_early,
                             input logic [1:0] exp_resp, input int hold);
    do_aw(id, addr, len, burst);
    do_w(addr, len, burst, wlast_early);
    wait_b(id, exp_resp, hold);
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic push);
    logic [31:0] a;
    rexp_t e;
    int t;
    if (push) begin
      a = addr;
      for (int k = 0; k <= int'(len); k++) begin
        e.resp = (burst == 2'b10 || !((a - BASE) < MEMB)) ? 2'b10 : 2'b00;
        e.dat  = ((a - BASE) < MEMB) ? model[a[11:2]] : 32'h0;
        e.chk  = (burst != 2'b10);
        e.last = (k == int'(len));
        sb.push_back(e);
        if (burst != 2'b00) a = a + 32'd4;
      end
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    checks++;
    if (ARREADY !== 1'b1) begin errors++; $display("FAIL ar_timeout ARREADY=%b required 1", ARREADY); end
    @(negedge ACLK);
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1) begin errors++; $display("FAIL r_latency RVALID=%b required 1 a cycle after AR", RVALID); end
  endtask

  task automatic collect_r(input logic [3:0] id, input logic toggle, output int cycles);
    int t;
    logic held_v;
    logic [31:0] held_d;
    logic held_l;
    rexp_t e;
    t = 0; cycles = 0; held_v = 1'b0; held_d = '0; held_l = 1'b0;
    while (sb.size() > 0 && t < 400) begin
      RREADY = toggle ? t[0] : 1'b1;
      if (held_v) begin
        checks++;
        if (RVALID !== 1'b1 || RDATA !== held_d || RLAST !== held_l) begin
          errors++; $display("FAIL r_stable RVALID=%b RDATA=%h RLAST=%b required 1 %h %b", RVALID, RDATA, RLAST, held_d, held_l);
        end
      end
      held_v = RVALID && !RREADY; held_d = RDATA; held_l = RLAST;
      if (RVALID && RREADY) begin
        e = sb.pop_front();
        checks++;
        if (RID !== id || RRESP !== e.resp || RLAST !== e.last || (e.chk && RDATA !== e.dat)) begin
          errors++;
          $display("FAIL r_beat RID=%h RDATA=%h RRESP=%b RLAST=%b required %h %h %b %b",
                   RID, RDATA, RRESP, RLAST, id, e.dat, e.resp, e.last);
        end
      end
      @(negedge ACLK);
      t++; cycles++;
    end
    RREADY = 1'b0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL r_timeout beats_left=%0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset();
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b110000) begin
      errors++; $display("FAIL reset_hs AW/AR/W/B/R/L=%b required 110000", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
    end
    checks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || BID !== 4'h0 || RID !== 4'h0 || RDATA !== 32'h0) begin
      errors++; $display("FAIL reset_vals BRESP=%b RRESP=%b BID=%h RID=%h RDATA=%h required zeros", BRESP, RRESP, BID, RID, RDATA);
    end
    ARESETn = 1'b1;
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checks++;
      if (WREADY !== 1'b0) begin errors++; $display("FAIL w_before_aw WREADY=%b required 0", WREADY); end
    end
    WVALID = 1'b0;
  endtask

  task automatic test_single();
    int cyc;
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    write_burst(4'h9, 32'h10, 8'd0, 2'b01, 1'b0, 2'b00, 0);
    issue_ar(4'h6, 32'h10, 8'd0, 2'b01, 1'b1);
    collect_r(4'h6, 1'b0, cyc);
  endtask

  task automatic test_incr();
    int cyc;
    for (int k = 0; k < 16; k++) begin wbuf[k] = 32'(k + 1); sbuf[k] = 4'hF; end
    write_burst(4'h2, 32'h100, 8'd15, 2'b01, 1'b0, 2'b00, 0);
    issue_ar(4'h7, 32'h100, 8'd15, 2'b01, 1'b1);
    collect_r(4'h7, 1'b0, cyc);
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL incr_rate cycles=%0d required 16", cyc); end
  endtask

  task automatic test_strobe_backpressure();
    int cyc;
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    write_burst(4'h1, 32'h300, 8'd0, 2'b01, 1'b0, 2'b00, 0);
    wbuf[0] = 32'h0000_0000; sbuf[0] = 4'b0101;
    write_burst(4'h1, 32'h300, 8'd0, 2'b01, 1'b0, 2'b00, 0);
    issue_ar(4'h3, 32'h300, 8'd0, 2'b01, 1'b1);
    collect_r(4'h3, 1'b1, cyc);
    issue_ar(4'h4, 32'h104, 8'd3, 2'b01, 1'b1);
    collect_r(4'h4, 1'b1, cyc);
  endtask

  task automatic test_errors();
    int cyc;
    wbuf[0] = 32'hA5A5_A5A5; sbuf[0] = 4'hF;
    write_burst(4'h5, 32'h0, 8'd0, 2'b01, 1'b0, 2'b00, 0);
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    write_burst(4'hA, BASE + MEMB - 4, 8'd1, 2'b01, 1'b0, 2'b10, 0);
    issue_ar(4'h1, BASE + MEMB - 4, 8'd0, 2'b01, 1'b1);
    collect_r(4'h1, 1'b0, cyc);
    issue_ar(4'h2, 32'h0, 8'd0, 2'b01, 1'b1);
    collect_r(4'h2, 1'b0, cyc);
    issue_ar(4'h3, BASE + MEMB, 8'd0, 2'b01, 1'b1);
    collect_r(4'h3, 1'b0, cyc);
    wbuf[0] = 32'h3333_0001; wbuf[1] = 32'h3333_0002;
    write_burst(4'hB, 32'h400, 8'd1, 2'b01, 1'b1, 2'b10, 0);
    issue_ar(4'hC, 32'h400, 8'd1, 2'b01, 1'b1);
    collect_r(4'hC, 1'b0, cyc);
    issue_ar(4'hD, 32'h100, 8'd3, 2'b10, 1'b1);
    collect_r(4'hD, 1'b0, cyc);
  endtask

  task automatic test_concurrent();
    int cyc;
    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hC000_0000 + 32'(k); sbuf[k] = 4'hF; end
    fork
      write_burst(4'h3, 32'h200, 8'd3, 2'b01, 1'b0, 2'b00, 5);
      begin
        issue_ar(4'h5, 32'h100, 8'd15, 2'b01, 1'b1);
        collect_r(4'h5, 1'b0, cyc);
      end
    join
    issue_ar(4'h8, 32'h200, 8'd3, 2'b01, 1'b1);
    collect_r(4'h8, 1'b0, cyc);
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    issue_ar(4'h9, 32'h100, 8'd15, 2'b01, 1'b0);
    RREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || RDATA !== 32'h0 || RLAST !== 1'b0) begin
      errors++; $display("FAIL reset_mid RVALID=%b RDATA=%h RLAST=%b required 0 0 0", RVALID, RDATA, RLAST);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0 || BVALID !== 1'b0) begin
      errors++; $display("FAIL reset_release ARREADY=%b RVALID=%b BVALID=%b required 1 0 0", ARREADY, RVALID, BVALID);
    end
    issue_ar(4'hE, 32'h108, 8'd3, 2'b01, 1'b1);
    collect_r(4'hE, 1'b0, cyc);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    repeat (3) @(negedge ACLK);
    test_reset();
    test_single();
    test_incr();
    test_strobe_backpressure();
    test_errors();
    test_concurrent();
    test_reset_mid_read();
    repeat (2) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
